alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/mult_iter.sv | 65 ++++++
 rtl/alu_exec_unit.sv | 81 ++++++++
 tb/tb_alu_exec_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, widths, FSM state type and the single-cycle
//             ALU function for the execute unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int MUL_ITERS = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BCMP = 4'b1000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Unrecognised opcodes (and MULT, which is handled elsewhere) yield zero.
    function automatic logic [DATA_W-1:0] alu_single(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        res = '0;
        case (op)
            OP_AND:          res = a & b;
            OP_OR:           res = a | b;
            OP_ADD:          res = a + b;
            OP_SUB, OP_BCMP: res = a - b;
            OP_SLT:          res = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default:         res = '0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_iter.sv
// ============================================================================
//  Module   : mult_iter
//  Purpose  : Radix-2 shift-add multiplier, one iteration per clock, low word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_iter
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int              CNT_W = $clog2(MUL_ITERS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITERS - 1);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

    // done/product describe the iteration happening at the coming edge, so
    // the owner can register the final product on the same edge.
    assign done_o    = r_busy && (r_cnt == LAST);
    assign product_o = w_acc_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start_i) begin
            r_a    <= a_i;
            r_b    <= b_i;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            // Counter parks on the terminal value instead of wrapping.
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : ALU execute stage: single-cycle ops plus a 32-cycle iterative
//             multiply, with ready/valid handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    state_t            r_state;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;
    logic [DATA_W-1:0] w_single;

    assign ready_o     = (r_state == IDLE);
    assign w_accept    = valid_i && ready_o;
    assign w_mul_start = w_accept && (ctrl_i == OP_MULT);
    assign w_single    = alu_single(ctrl_i, src1_i, src2_i);

    mult_iter u_mult_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_mul_start),
        .a_i       (src1_i),
        .b_i       (src2_i),
        .done_o    (w_mul_done),
        .product_o (w_mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            result_o <= '0;
            zero_o   <= 1'b1;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (ctrl_i == OP_MULT) begin
                            r_state <= MUL;
                        end else begin
                            result_o <= w_single;
                            zero_o   <= (w_single == '0);
                            valid_o  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        result_o <= w_mul_product;
                        zero_o   <= (w_mul_product == '0);
                        valid_o  <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit against a cycle model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [3:0]  ctrl_i = 4'b0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: cycles left in a multiply, pending product, outputs.
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_result = '0;
    logic        m_zero = 1'b1;
    logic        m_valid = 1'b0;

    alu_exec_unit dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1000: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk_i) begin
        logic [63:0] prod;
        if (rst_i) begin
            m_left   = 0;
            m_result = '0;
            m_zero   = 1'b1;
            m_valid  = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_result = m_pend;
                    m_zero   = (m_pend == 32'd0);
                    m_valid  = 1'b1;
                end
            end else if (valid_i) begin
                if (ctrl_i == 4'b0011) begin
                    prod   = {32'd0, src1_i} * {32'd0, src2_i};
                    m_pend = prod[31:0];
                    m_left = 32;
                end else begin
                    m_result = ref_op(ctrl_i, src1_i, src2_i);
                    m_zero   = (m_result == 32'd0);
                    m_valid  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("model_ready",  ready_o,  (m_left == 0));
            check("model_valid",  valid_o,  m_valid);
            check("model_result", result_o, m_result);
            check("model_zero",   zero_o,   m_zero);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i = 1'b1;
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    initial begin
        int n;
        logic [3:0] ops [8];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0011, 4'b0011};

        repeat (3) @(negedge clk_i);
        chk_en = 1'b1;
        check("rst_result", result_o, 32'd0);
        check("rst_zero",   zero_o,   1'b1);
        check("rst_valid",  valid_o,  1'b0);
        check("rst_ready",  ready_o,  1'b1);
        rst_i = 1'b0;

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_result", result_o, 32'h8000_0000);
        check("add_zero",   zero_o,   1'b0);
        check("add_valid",  valid_o,  1'b1);
        check("add_ready",  ready_o,  1'b1);
        check("model_add",  m_result, 32'h8000_0000);

        issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt_result", result_o, 32'd1);
        issue(4'b0110, 32'h1234, 32'h1234);
        check("sub_result", result_o, 32'd0);
        check("sub_zero",   zero_o,   1'b1);

        // MULT with a second request held high throughout the multiply.
        @(negedge clk_i);
        valid_i = 1'b1; ctrl_i = 4'b0011; src1_i = 32'h0001_0000; src2_i = 32'h0001_0001;
        @(negedge clk_i);
        check("mul_ready_e0", ready_o, 1'b0);
        ctrl_i = 4'b0010; src1_i = 32'd5; src2_i = 32'd6;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk_i);
            check("mul_ready_busy", ready_o, 1'b0);
        end
        @(negedge clk_i);
        check("mul_valid",  valid_o,  1'b1);
        check("mul_result", result_o, 32'h0001_0000);
        check("mul_ready_e32", ready_o, 1'b1);
        @(negedge clk_i);
        check("held_valid",  valid_o,  1'b1);
        check("held_result", result_o, 32'd11);
        valid_i = 1'b0;

        // MULT with src1_i disturbed mid-operation.
        issue(4'b0011, 32'hFFFF_FFFE, 32'h0000_0003);
        n = 0;
        while (!valid_o && n < 40) begin
            @(negedge clk_i);
            n++;
            if (n == 10) src1_i = 32'h1234_5678;
        end
        check("mul2_latency", n, 32);
        check("mul2_result", result_o, 32'hFFFF_FFFA);
        check("model_mul2",  m_result, 32'hFFFF_FFFA);

        // Reset landing on E10 of a multiply.
        issue(4'b0011, 32'h0000_0007, 32'h0000_0009);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_ready",  ready_o,  1'b1);
        check("abort_result", result_o, 32'd0);
        check("abort_valid",  valid_o,  1'b0);
        rst_i = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk_i);
            check("abort_no_valid", valid_o, 1'b0);
        end

        issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
        check("undef_result", result_o, 32'd0);
        check("undef_zero",   zero_o,   1'b1);
        check("undef_valid",  valid_o,  1'b1);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk_i);
            rst_i   = ($urandom_range(0, 199) == 0);
            valid_i = ($urandom_range(0, 3) != 0);
            n = int'($urandom_range(0, 9));
            ctrl_i  = (n < 8) ? ops[n] : 4'($urandom);
            case ($urandom_range(0, 3))
                0:       src1_i = 32'h8000_0000;
                1:       src1_i = 32'($urandom_range(0, 3));
                default: src1_i = $urandom;
            endcase
            src2_i = ($urandom_range(0, 3) == 0) ? src1_i : $urandom;
        end
        @(negedge clk_i);
        rst_i = 1'b0; valid_i = 1'b0;
        repeat (40) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
